// File: rtl/ff_exc_pkg.sv
// Shared definitions for the flip-flop excitation driver and its checker.
package ff_exc_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // One cycle of excitation for the SR, JK and T flip-flops
  typedef struct packed {
    logic s;
    logic r;
    logic j;
    logic k;
    logic t;
  } exc_t;

  // Reset excitation clears SR and JK and holds T
  localparam exc_t EXC_RST = '{s: 1'b0, r: 1'b1, j: 1'b0, k: 1'b1, t: 1'b0};

  localparam int unsigned CHECK_LAT_MIN = 1;
  localparam int unsigned CHECK_LAT_MAX = 4;

  // Keep the check latency inside the supported delay-line depth
  function automatic int unsigned clamp_lat(input int unsigned lat);
    if (lat < CHECK_LAT_MIN) return CHECK_LAT_MIN;
    if (lat > CHECK_LAT_MAX) return CHECK_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/ff_exc_checker.sv
// Delays {active,d} by CHECK_LAT cycles, compares against q_fb and counts mismatches.
module ff_exc_checker
  import ff_exc_pkg::*;
#(
  parameter int unsigned ERR_W     = 8,
  parameter int unsigned CHECK_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_active,
  input  logic             i_d,
  input  logic             i_q_fb,
  input  logic             i_clr_err,
  output logic             o_mismatch,
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam int unsigned LAT = clamp_lat(CHECK_LAT);
  localparam logic [ERR_W-1:0] CNT_MAX = '1;

  logic [LAT-1:0]   r_dly_act;
  logic [LAT-1:0]   r_dly_d;
  logic             r_mismatch;
  logic [ERR_W-1:0] r_err_cnt;
  logic             w_fail;

  // Oldest stage of the delay line is bit LAT-1
  assign w_fail = r_dly_act[LAT-1] && (i_q_fb != r_dly_d[LAT-1]);

  // Delay line for the expected bit and its qualifier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dly_act <= '0;
      r_dly_d   <= '0;
    end else begin
      r_dly_act <= LAT'({r_dly_act, i_active});
      r_dly_d   <= LAT'({r_dly_d, i_d});
    end
  end

  // Mismatch pulse and saturating counter; clear wins over a same-cycle count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mismatch <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_mismatch <= w_fail;
      if (i_clr_err) begin
        r_err_cnt <= '0;
      end else if (w_fail && (r_err_cnt != CNT_MAX)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign o_mismatch = r_mismatch;
  assign o_err_cnt  = r_err_cnt;

endmodule

// File: rtl/ff_excitation_driver.sv
// Serialises target words MSB-first into SR/JK/T excitation and checks the returned q.
module ff_excitation_driver
  import ff_exc_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ERR_W     = 8,
  parameter int unsigned CHECK_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_in_ready,
  output logic             o_s,
  output logic             o_r,
  output logic             o_j,
  output logic             o_k,
  output logic             o_t,
  output logic             o_active,
  output logic             o_word_done,
  input  logic             i_q_fb,
  input  logic             i_clr_err,
  output logic             o_mismatch,
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam int unsigned IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] w_sh_nxt;
  logic             r_q_model;
  exc_t             r_exc;
  logic             r_active;
  logic             r_word_done;
  logic             r_in_ready;
  logic             w_accept;
  logic             w_drive;
  logic             w_d;

  // r_sh[WIDTH-1] is the bit currently on the excitation outputs
  assign w_accept = i_in_valid && r_in_ready;

  // Next-state, shift and bit-index logic
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_sh_nxt    = r_sh;
    w_drive     = 1'b0;
    w_d         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
          w_idx_nxt   = IDX_LAST;
          w_sh_nxt    = i_in_data;
          w_drive     = 1'b1;
          w_d         = i_in_data[WIDTH-1];
        end
      end
      ST_SHIFT: begin
        if (r_idx != '0) begin
          w_idx_nxt = r_idx - 1'b1;
          w_sh_nxt  = r_sh << 1;
          w_drive   = 1'b1;
          w_d       = r_sh[WIDTH-2];
        end else if (w_accept) begin
          w_idx_nxt = IDX_LAST;
          w_sh_nxt  = i_in_data;
          w_drive   = 1'b1;
          w_d       = i_in_data[WIDTH-1];
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, shift register, bit index and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_sh       <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_sh       <= w_sh_nxt;
      r_in_ready <= (w_state_nxt == ST_IDLE) || (w_idx_nxt == '0);
    end
  end

  // Excitation registers; when idle SR/JK hold and T is released so the flip-flops keep state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exc       <= EXC_RST;
      r_q_model   <= 1'b0;
      r_active    <= 1'b0;
      r_word_done <= 1'b0;
    end else if (w_drive) begin
      r_exc.s     <= w_d;
      r_exc.r     <= ~w_d;
      r_exc.j     <= w_d;
      r_exc.k     <= ~w_d;
      r_exc.t     <= w_d ^ r_q_model;
      r_q_model   <= w_d;
      r_active    <= 1'b1;
      r_word_done <= (w_idx_nxt == '0);
    end else begin
      r_exc.t     <= 1'b0;
      r_active    <= 1'b0;
      r_word_done <= 1'b0;
    end
  end

  ff_exc_checker #(
    .ERR_W     (ERR_W),
    .CHECK_LAT (CHECK_LAT)
  ) u_checker (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_active   (r_active),
    .i_d        (r_exc.s),
    .i_q_fb     (i_q_fb),
    .i_clr_err  (i_clr_err),
    .o_mismatch (o_mismatch),
    .o_err_cnt  (o_err_cnt)
  );

  assign o_in_ready  = r_in_ready;
  assign o_s         = r_exc.s;
  assign o_r         = r_exc.r;
  assign o_j         = r_exc.j;
  assign o_k         = r_exc.k;
  assign o_t         = r_exc.t;
  assign o_active    = r_active;
  assign o_word_done = r_word_done;

endmodule

// File: tb/tb_ff_excitation_driver.sv
// Scoreboard bench: stimulus queues hand-computed per-bit expectations, a negedge monitor checks them.
module tb_ff_excitation_driver;

  localparam int unsigned LAT = 1;

  typedef struct packed {
    logic s;
    logic r;
    logic j;
    logic k;
    logic t;
    logic wd;
    logic mis;
  } exp_t;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       clr_err  = 1'b0;
  logic       clr_err2 = 1'b0;
  logic       q_fb, q_fb2;
  logic       ffq, ffq2;

  logic       in_ready, s, r, j, k, t, active, word_done, mismatch;
  logic [7:0] err_cnt;
  logic       in_ready2, s2, r2, j2, k2, t2, active2, word_done2, mismatch2;
  logic [1:0] err_cnt2;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   mode  = 0;  // 0 loop SR model, 1 force 0, 2 inverted
  int   mode2 = 0;
  int   run_len = 0;
  int   max_run = 0;
  exp_t exp_q[$];
  int   mis_q[$];
  exp_t mon_e;
  logic mon_mis;

  always #5 clk = ~clk;

  ff_excitation_driver #(.WIDTH(8), .ERR_W(8), .CHECK_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready(in_ready), .o_s(s), .o_r(r), .o_j(j), .o_k(k), .o_t(t),
    .o_active(active), .o_word_done(word_done), .i_q_fb(q_fb),
    .i_clr_err(clr_err), .o_mismatch(mismatch), .o_err_cnt(err_cnt)
  );

  ff_excitation_driver #(.WIDTH(8), .ERR_W(2), .CHECK_LAT(LAT)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready(in_ready2), .o_s(s2), .o_r(r2), .o_j(j2), .o_k(k2), .o_t(t2),
    .o_active(active2), .o_word_done(word_done2), .i_q_fb(q_fb2),
    .i_clr_err(clr_err2), .o_mismatch(mismatch2), .o_err_cnt(err_cnt2)
  );

  // SR flip-flops under test; s=r=0 clears
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ffq <= 1'b0;
    else if (s && !r) ffq <= 1'b1;
    else if (!s) ffq <= 1'b0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ffq2 <= 1'b0;
    else if (s2 && !r2) ffq2 <= 1'b1;
    else if (!s2) ffq2 <= 1'b0;
  end

  assign q_fb  = (mode == 0)  ? ffq  : (mode == 1)  ? 1'b0 : ~ffq;
  assign q_fb2 = (mode2 == 0) ? ffq2 : (mode2 == 1) ? 1'b0 : ~ffq2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, req);
    end
  endtask

  // Monitor: pops one expectation per active cycle and checks mismatch timing
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (active) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (exp_q.size() == 0) begin
          chk("unexpected_active", 32'(active), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("s", 32'(s), 32'(mon_e.s));
          chk("r", 32'(r), 32'(mon_e.r));
          chk("j", 32'(j), 32'(mon_e.j));
          chk("k", 32'(k), 32'(mon_e.k));
          chk("t", 32'(t), 32'(mon_e.t));
          chk("word_done", 32'(word_done), 32'(mon_e.wd));
          chk("in_ready_shift", 32'(in_ready), 32'(mon_e.wd));
          if (mon_e.mis) mis_q.push_back(cyc + int'(LAT) + 1);
        end
      end else begin
        run_len = 0;
        chk("t_idle", 32'(t), 32'd0);
        chk("word_done_idle", 32'(word_done), 32'd0);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
      end
      mon_mis = (mis_q.size() > 0) && (mis_q[0] == cyc);
      if (mon_mis) void'(mis_q.pop_front());
      chk("mismatch", 32'(mismatch), 32'(mon_mis));
    end
  end

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({nm, "_s"}, 32'(s), 32'd0);
    chk({nm, "_r"}, 32'(r), 32'd1);
    chk({nm, "_j"}, 32'(j), 32'd0);
    chk({nm, "_k"}, 32'(k), 32'd1);
    chk({nm, "_t"}, 32'(t), 32'd0);
    chk({nm, "_active"}, 32'(active), 32'd0);
    chk({nm, "_word_done"}, 32'(word_done), 32'd0);
    chk({nm, "_mismatch"}, 32'(mismatch), 32'd0);
    chk({nm, "_err_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    mis_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Queue expectations then hold in_valid until the word is accepted
  task automatic send_word(input logic [7:0] d, input logic [7:0] tmask, input logic [7:0] mmask);
    exp_t e;
    int   n;
    for (int i = 7; i >= 0; i--) begin
      e.s   = d[i];
      e.r   = ~d[i];
      e.j   = d[i];
      e.k   = ~d[i];
      e.t   = tmask[i];
      e.wd  = (i == 0);
      e.mis = mmask[i];
      exp_q.push_back(e);
    end
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (LAT + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    // Reset values
    #1 rst_n = 1'b0;
    #12 check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1) A5 with looped SR flip-flop
    send_word(8'hA5, 8'b1111_0111, 8'h00);
    drain();
    chk("t1_err_cnt", 32'(err_cnt), 32'd0);

    // 2) FF then 00 back to back
    do_reset();
    max_run = 0;
    send_word(8'hFF, 8'b1000_0000, 8'h00);
    send_word(8'h00, 8'b1000_0000, 8'h00);
    drain();
    chk("t2_contiguous_active", 32'(max_run), 32'd16);

    // 3) 0F with q_fb forced 0
    do_reset();
    mode = 1;
    send_word(8'h0F, 8'b0000_1000, 8'h0F);
    drain();
    chk("t3_err_cnt", 32'(err_cnt), 32'd4);
    mode = 0;

    // 4) 2-bit counter saturation and clear on a mismatch cycle
    do_reset();
    mode2 = 2;
    send_word(8'hA5, 8'b1111_0111, 8'h00);
    drain();
    chk("t4_err_sat", 32'(err_cnt2), 32'd3);
    send_word(8'hA5, 8'b0111_0111, 8'h00);
    n = 0;
    while (!mismatch2 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t4_mismatch_seen", 32'(mismatch2), 32'd1);
    clr_err2 = 1'b1;
    @(posedge clk);
    #1 clr_err2 = 1'b0;
    chk("t4_err_cleared", 32'(err_cnt2), 32'd0);
    chk("t4_pulse_on_clear", 32'(mismatch2), 32'd1);
    drain();
    chk("t4_err_resat", 32'(err_cnt2), 32'd3);
    mode2 = 0;

    // 5) Reset in the middle of C3
    do_reset();
    send_word(8'hC3, 8'b1010_0010, 8'h00);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t5_midword");
    exp_q.delete();
    mis_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 send_word(8'h80, 8'b1100_0000, 8'h00);
    drain();
    chk("t5_err_cnt", 32'(err_cnt), 32'd0);

    // 6) Idle hold after 01; q_fb ignored once drained
    do_reset();
    send_word(8'h01, 8'b0000_0001, 8'h00);
    drain();
    mode = 1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("t6_s", 32'(s), 32'd1);
      chk("t6_r", 32'(r), 32'd0);
      chk("t6_j", 32'(j), 32'd1);
      chk("t6_k", 32'(k), 32'd0);
      chk("t6_t", 32'(t), 32'd0);
      chk("t6_active", 32'(active), 32'd0);
    end
    chk("t6_err_cnt", 32'(err_cnt), 32'd0);
    mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
